// File: rtl/cae_mc_pkg.sv
// Shared definitions for the cae_mc access controller: register map, CTRL/STATUS
// field positions and the per-channel run state encoding.
package cae_mc_pkg;

  localparam int CAE_ADDR_WIDTH = 8;

  localparam int REG_CTRL    = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_IRQ_EN  = 2;
  localparam int REG_CH_BASE = 16;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_SEL_LSB   = 8;
  localparam int SEL_W          = 3;

  localparam int STATUS_DONE_LSB = 16;
  localparam int STATUS_ERR_BIT  = 31;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } chState_e;

endpackage

// File: rtl/cae_mc_canal_fsm.sv
// Run-control FSM for one path-search core: IDLE -> RUN on start, RUN -> DONE on
// pronto, DONE -> IDLE on a done clear; abort returns to IDLE from anywhere.
module cae_mc_canal_fsm
  import cae_mc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic abort_i,
  input  logic clrDone_i,
  input  logic pronto_i,
  output logic busy_o,
  output logic done_o,
  output logic startPulse_o,
  output logic abortPulse_o
);

  chState_e state_q;
  logic     startPulse_q;
  logic     abortPulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CH_IDLE;
      startPulse_q <= 1'b0;
      abortPulse_q <= 1'b0;
    end else begin
      startPulse_q <= 1'b0;
      abortPulse_q <= 1'b0;
      // Abort outranks every other event, including a start in the same write.
      if (abort_i) begin
        state_q      <= CH_IDLE;
        abortPulse_q <= 1'b1;
      end else begin
        case (state_q)
          CH_IDLE: if (start_i) begin
            state_q      <= CH_RUN;
            startPulse_q <= 1'b1;
          end
          CH_RUN:  if (pronto_i)  state_q <= CH_DONE;
          CH_DONE: if (clrDone_i) state_q <= CH_IDLE;
          default: state_q <= CH_IDLE;
        endcase
      end
    end
  end

  assign busy_o       = (state_q == CH_RUN);
  assign done_o       = (state_q == CH_DONE);
  assign startPulse_o = startPulse_q;
  assign abortPulse_o = abortPulse_q;

endmodule

// File: rtl/cae_mc.sv
// Avalon-MM slave bridging a host CPU to NUM_CH path-search cores: register file,
// obstacle write routing, GMA read pipeline, per-channel run control and interrupt.
module cae_mc
  import cae_mc_pkg::*;
#(
  parameter int ADDR_WIDTH     = CAE_ADDR_WIDTH,
  parameter int AV_DATA_WIDTH  = 32,
  parameter int AV_ADDR_WIDTH  = 32,
  parameter int NUM_CH         = 2,
  parameter int RD_LATENCY     = 1,
  parameter int BASE_OBSTACULO = 1024,
  parameter int BASE_GMA       = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [AV_ADDR_WIDTH-1:0]       av_addr_in,
  input  logic [AV_DATA_WIDTH-1:0]       av_data_in,
  input  logic                           av_write_in,
  input  logic                           av_read_in,
  output logic [AV_DATA_WIDTH-1:0]       av_data_out,
  output logic                           av_readdatavalid_out,
  output logic                           av_waitrequest_out,
  output logic                           irq_out,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   core_addr_fonte_out,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   core_addr_destino_out,
  output logic [NUM_CH-1:0]              core_start_out,
  output logic [NUM_CH-1:0]              core_abort_out,
  input  logic [NUM_CH-1:0]              core_pronto_in,
  output logic [NUM_CH-1:0]              obstaculos_wr_enable_out,
  output logic [ADDR_WIDTH-1:0]          obstaculos_wr_addr_out,
  output logic                           obstaculos_wr_data_out,
  output logic [ADDR_WIDTH-1:0]          gma_read_addr_out,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   gma_read_data_in
);

  logic [SEL_W-1:0]                   chSel_q, rdCh_q, newSel, gmaSel;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  fonte_q, destino_q;
  logic [NUM_CH-1:0]                  irqEn_q, busyVec, doneVec;
  logic [NUM_CH-1:0]                  startVec, abortVec, clrVec, obsEn;
  logic [NUM_CH-1:0]                  isFonte, isDestino;
  logic                               err_q, irq_q, errSet;
  logic                               rdPending_q, rdValid_q;
  logic [2:0]                         rdCnt_q;
  logic [ADDR_WIDTH-1:0]              gmaAddr_q, obsOffset, gmaOffset;
  logic [AV_DATA_WIDTH-1:0]           rdData_q, regData, gmaWord;
  logic                               isCtrl, isStatus, isIrqEn, inObs, inGma;
  logic                               ctrlWr, statusWr, newSelOk, chSelOk, rdAccept;
  logic                               unusedData;

  assign isCtrl    = (av_addr_in == AV_ADDR_WIDTH'(REG_CTRL));
  assign isStatus  = (av_addr_in == AV_ADDR_WIDTH'(REG_STATUS));
  assign isIrqEn   = (av_addr_in == AV_ADDR_WIDTH'(REG_IRQ_EN));
  assign inObs     = (av_addr_in >= AV_ADDR_WIDTH'(BASE_OBSTACULO)) &&
                     (av_addr_in <  AV_ADDR_WIDTH'(BASE_OBSTACULO + 2**ADDR_WIDTH));
  assign inGma     = (av_addr_in >= AV_ADDR_WIDTH'(BASE_GMA)) &&
                     (av_addr_in <  AV_ADDR_WIDTH'(BASE_GMA + 2**ADDR_WIDTH));
  assign obsOffset = av_addr_in[ADDR_WIDTH-1:0] - ADDR_WIDTH'(BASE_OBSTACULO);
  assign gmaOffset = av_addr_in[ADDR_WIDTH-1:0] - ADDR_WIDTH'(BASE_GMA);
  assign newSel    = av_data_in[CTRL_SEL_LSB +: SEL_W];
  assign newSelOk  = ({1'b0, newSel}  < 4'(NUM_CH));
  assign chSelOk   = ({1'b0, chSel_q} < 4'(NUM_CH));
  assign ctrlWr    = av_write_in & isCtrl;
  assign statusWr  = av_write_in & isStatus;
  assign rdAccept  = av_read_in & ~av_write_in & ~rdPending_q;
  assign unusedData = ^av_data_in;

  // Per-channel command decode plus every condition that latches the sticky error flag.
  always_comb begin
    startVec  = '0;
    abortVec  = '0;
    clrVec    = '0;
    obsEn     = '0;
    isFonte   = '0;
    isDestino = '0;
    errSet    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ctrlWr && newSel == SEL_W'(c)) begin
        startVec[c] = av_data_in[CTRL_START_BIT];
        abortVec[c] = av_data_in[CTRL_ABORT_BIT];
      end
      clrVec[c]    = statusWr & av_data_in[STATUS_DONE_LSB + c];
      isFonte[c]   = (av_addr_in == AV_ADDR_WIDTH'(REG_CH_BASE + 2*c));
      isDestino[c] = (av_addr_in == AV_ADDR_WIDTH'(REG_CH_BASE + 2*c + 1));
      if (av_write_in && inObs && chSelOk && chSel_q == SEL_W'(c)) begin
        if (busyVec[c]) errSet = 1'b1;
        else            obsEn[c] = 1'b1;
      end
      if (startVec[c] && !abortVec[c] && (busyVec[c] || doneVec[c])) errSet = 1'b1;
      if (av_write_in && (isFonte[c] || isDestino[c]) && busyVec[c]) errSet = 1'b1;
    end
    if (ctrlWr && !newSelOk && (av_data_in[CTRL_START_BIT] || av_data_in[CTRL_ABORT_BIT]))
      errSet = 1'b1;
    if (av_write_in && inObs && !chSelOk) errSet = 1'b1;
    if (rdAccept && inGma && !chSelOk)    errSet = 1'b1;
    if (av_write_in && av_read_in)        errSet = 1'b1;
  end

  always_comb begin
    gmaSel  = rdPending_q ? rdCh_q : chSel_q;
    gmaWord = '0;
    regData = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gmaSel == SEL_W'(c)) gmaWord[ADDR_WIDTH-1:0] = gma_read_data_in[c*ADDR_WIDTH +: ADDR_WIDTH];
      if (isFonte[c])   regData[ADDR_WIDTH-1:0] = fonte_q[c];
      if (isDestino[c]) regData[ADDR_WIDTH-1:0] = destino_q[c];
    end
    if (isCtrl) regData[CTRL_SEL_LSB +: SEL_W] = chSel_q;
    if (isStatus) begin
      regData[NUM_CH-1:0]                = busyVec;
      regData[STATUS_DONE_LSB +: NUM_CH] = doneVec;
      regData[STATUS_ERR_BIT]            = err_q;
    end
    if (isIrqEn) regData[NUM_CH-1:0] = irqEn_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chSel_q   <= '0;
      irqEn_q   <= '0;
      fonte_q   <= '0;
      destino_q <= '0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrlWr) chSel_q <= newSel;
      if (av_write_in && isIrqEn) irqEn_q <= av_data_in[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (av_write_in && isFonte[c] && !busyVec[c])   fonte_q[c]   <= av_data_in[ADDR_WIDTH-1:0];
        if (av_write_in && isDestino[c] && !busyVec[c]) destino_q[c] <= av_data_in[ADDR_WIDTH-1:0];
      end
      if (errSet)                                    err_q <= 1'b1;
      else if (statusWr && av_data_in[STATUS_ERR_BIT]) err_q <= 1'b0;
      irq_q <= |(doneVec & irqEn_q);
    end
  end

  // Register reads answer next cycle; GMA reads wait RD_LATENCY cycles for the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPending_q <= 1'b0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      rdCnt_q     <= '0;
      rdCh_q      <= '0;
      gmaAddr_q   <= '0;
    end else begin
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      if (rdPending_q) begin
        if (rdCnt_q == 3'd0) begin
          rdPending_q <= 1'b0;
          rdValid_q   <= 1'b1;
          rdData_q    <= gmaWord;
        end else begin
          rdCnt_q <= rdCnt_q - 3'd1;
        end
      end else if (rdAccept) begin
        if (inGma && chSelOk) begin
          gmaAddr_q <= gmaOffset;
          rdCh_q    <= chSel_q;
          if (RD_LATENCY == 0) begin
            rdValid_q <= 1'b1;
            rdData_q  <= gmaWord;
          end else begin
            rdPending_q <= 1'b1;
            rdCnt_q     <= 3'(RD_LATENCY - 1);
          end
        end else begin
          rdValid_q <= 1'b1;
          rdData_q  <= regData;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cae_mc_canal_fsm u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (startVec[c]),
      .abort_i      (abortVec[c]),
      .clrDone_i    (clrVec[c]),
      .pronto_i     (core_pronto_in[c]),
      .busy_o       (busyVec[c]),
      .done_o       (doneVec[c]),
      .startPulse_o (core_start_out[c]),
      .abortPulse_o (core_abort_out[c])
    );
  end

  assign av_data_out              = rdData_q;
  assign av_readdatavalid_out     = rdValid_q;
  assign av_waitrequest_out       = av_read_in & rdPending_q;
  assign irq_out                  = irq_q;
  assign core_addr_fonte_out      = fonte_q;
  assign core_addr_destino_out    = destino_q;
  assign obstaculos_wr_enable_out = obsEn;
  assign obstaculos_wr_addr_out   = (|obsEn) ? obsOffset : '0;
  assign obstaculos_wr_data_out   = (|obsEn) & av_data_in[0];
  assign gma_read_addr_out        = gmaAddr_q;

endmodule

// File: tb/tb_cae_mc.sv
// Self-checking bench for cae_mc: random register/obstacle/GMA traffic checked
// against a channel-level model of run state, error flag and register contents.
module tb_cae_mc;

  localparam int AW = 8, DW = 32, NCH = 2, RDL = 2, BOBS = 1024, BGMA = 4096;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [31:0]       av_addr = '0, av_wdata = '0;
  logic              av_write = 1'b0, av_read = 1'b0;
  logic [DW-1:0]     av_rdata;
  logic              av_rvalid, av_wait, irq;
  logic [NCH*AW-1:0] fonteOut, destinoOut, gmaData = '0;
  logic [NCH-1:0]    startOut, abortOut, pronto = '0, obsEnOut;
  logic [AW-1:0]     obsAddrOut, gmaAddrOut;
  logic              obsDataOut;

  int total = 0, bad = 0;

  bit          mRun[NCH], mDone[NCH], mErr;
  logic [AW-1:0] mFonte[NCH], mDest[NCH];
  logic [NCH-1:0] mIrqEn;

  cae_mc #(.ADDR_WIDTH(AW), .AV_DATA_WIDTH(DW), .AV_ADDR_WIDTH(32), .NUM_CH(NCH),
           .RD_LATENCY(RDL), .BASE_OBSTACULO(BOBS), .BASE_GMA(BGMA)) dut (
    .clk(clk), .rst_n(rst_n), .av_addr_in(av_addr), .av_data_in(av_wdata),
    .av_write_in(av_write), .av_read_in(av_read), .av_data_out(av_rdata),
    .av_readdatavalid_out(av_rvalid), .av_waitrequest_out(av_wait), .irq_out(irq),
    .core_addr_fonte_out(fonteOut), .core_addr_destino_out(destinoOut),
    .core_start_out(startOut), .core_abort_out(abortOut), .core_pronto_in(pronto),
    .obstaculos_wr_enable_out(obsEnOut), .obstaculos_wr_addr_out(obsAddrOut),
    .obstaculos_wr_data_out(obsDataOut), .gma_read_addr_out(gmaAddrOut),
    .gma_read_data_in(gmaData));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] expStatus();
    logic [31:0] s = '0;
    for (int c = 0; c < NCH; c++) begin
      s[c]      = mRun[c];
      s[16 + c] = mDone[c];
    end
    s[31] = mErr;
    return s;
  endfunction

  function automatic bit expIrq();
    bit r = 0;
    for (int c = 0; c < NCH; c++) r |= mDone[c] & mIrqEn[c];
    return r;
  endfunction

  // One bus cycle driven at a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input bit wr, input bit rd);
    @(negedge clk);
    av_addr = addr; av_wdata = data; av_write = wr; av_read = rd;
    @(negedge clk);
    av_write = 1'b0; av_read = 1'b0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, data, 1'b1, 1'b0);
  endtask

  // Read with bounded waits; lat counts negedges from accept to readdatavalid, -1 on timeout.
  task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output int lat);
    int guard = 0;
    @(negedge clk);
    av_addr = addr; av_read = 1'b1; #1;
    while (av_wait && guard < 50) begin @(negedge clk); #1; guard++; end
    @(negedge clk);
    av_read = 1'b0; lat = 1;
    while (!av_rvalid && lat < 20) begin @(negedge clk); lat++; end
    data = av_rdata;
    if (!av_rvalid) lat = -1;
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mRun[c] = 0; mDone[c] = 0; mFonte[c] = '0; mDest[c] = '0;
    end
    mErr = 0; mIrqEn = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat;
    modelReset();
    #1;
    total++;
    if ({startOut, abortOut, obsEnOut, av_rvalid, irq, fonteOut} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%h exp=0", {startOut, abortOut, obsEnOut, av_rvalid, irq, fonteOut});
    end
    @(negedge clk); rst_n = 1'b1;
    busRead(32'd1, d, lat);
    total++;
    if (lat !== 1) begin bad++; $display("[TB] FAIL reset_status_latency got=%0d exp=1", lat); end
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL reset_status got=%h exp=%h", d, expStatus()); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_registers();
    logic [31:0] d; int lat;
    for (int c = 0; c < NCH; c++) begin
      mFonte[c] = AW'($urandom_range(0, 255));
      mDest[c]  = AW'($urandom_range(0, 255));
      busWrite(32'(16 + 2*c), {24'hABCDEF, mFonte[c]});
      busWrite(32'(17 + 2*c), {24'h123456, mDest[c]});
    end
    for (int c = 0; c < NCH; c++) begin
      busRead(32'(16 + 2*c), d, lat);
      total++;
      if (d !== 32'(mFonte[c])) begin bad++; $display("[TB] FAIL fonte_readback ch%0d got=%h exp=%h", c, d, mFonte[c]); end
      busRead(32'(17 + 2*c), d, lat);
      total++;
      if (d !== 32'(mDest[c])) begin bad++; $display("[TB] FAIL destino_readback ch%0d got=%h exp=%h", c, d, mDest[c]); end
      total++;
      if (fonteOut[c*AW +: AW] !== mFonte[c] || destinoOut[c*AW +: AW] !== mDest[c]) begin
        bad++; $display("[TB] FAIL core_addr_ports ch%0d got=%h/%h exp=%h/%h", c,
                        fonteOut[c*AW +: AW], destinoOut[c*AW +: AW], mFonte[c], mDest[c]);
      end
    end
    mIrqEn = NCH'($urandom_range(0, 3));
    busWrite(32'd2, {30'h3FFFFFFF, mIrqEn});
    busRead(32'd2, d, lat);
    total++;
    if (d !== 32'(mIrqEn)) begin bad++; $display("[TB] FAIL irq_en_readback got=%h exp=%h", d, mIrqEn); end
    busWrite(32'd0, 32'h0000_0100);
    busRead(32'd0, d, lat);
    total++;
    if (d !== 32'h0000_0100) begin bad++; $display("[TB] FAIL ctrl_readback got=%h exp=00000100", d); end
  endtask

  task automatic test_start_done();
    logic [31:0] d; int lat;
    busWrite(32'd18, 32'd5); mFonte[1] = 8'd5;
    busWrite(32'd19, 32'd9); mDest[1]  = 8'd9;
    busWrite(32'd0, 32'h101); mRun[1] = 1;
    total++;
    if (startOut !== 2'b10) begin bad++; $display("[TB] FAIL start_pulse got=%b exp=10", startOut); end
    @(negedge clk);
    total++;
    if (startOut !== 2'b00) begin bad++; $display("[TB] FAIL start_pulse_width got=%b exp=00", startOut); end
    total++;
    if (fonteOut[AW +: AW] !== 8'd5) begin bad++; $display("[TB] FAIL fonte_ch1 got=%h exp=05", fonteOut[AW +: AW]); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_run got=%h exp=%h", d, expStatus()); end
    busWrite(32'd2, 32'd2); mIrqEn = 2'b10;
    pronto[1] = 1'b1;
    @(negedge clk);
    mRun[1] = 0; mDone[1] = 1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_early got=%b exp=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_after_done got=%b exp=%b", irq, expIrq()); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_done got=%h exp=%h", d, expStatus()); end
    busWrite(32'd1, 32'h0002_0000); mDone[1] = 0;
    @(negedge clk);
    total++;
    if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_cleared got=%b exp=%b", irq, expIrq()); end
    pronto[1] = 1'b0;
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_w1c got=%h exp=%h", d, expStatus()); end
  endtask

  task automatic test_obstacle();
    logic [31:0] d; int lat; logic [AW-1:0] off; bit bitv; logic [AW-1:0] keep;
    busWrite(32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      off  = (i == 0) ? AW'(7) : AW'($urandom_range(0, 255));
      bitv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      av_addr = 32'(BOBS) + 32'(off); av_wdata = {31'h5A5A5A5A, bitv}; av_write = 1'b1; #1;
      total++;
      if (obsEnOut !== 2'b01 || obsAddrOut !== off || obsDataOut !== bitv) begin
        bad++; $display("[TB] FAIL obstacle_write got=%b/%h/%b exp=01/%h/%b", obsEnOut, obsAddrOut, obsDataOut, off, bitv);
      end
      @(negedge clk); av_write = 1'b0;
    end
    busWrite(32'd0, 32'd1); mRun[0] = 1;
    @(negedge clk);
    av_addr = 32'(BOBS + 7); av_wdata = 32'd1; av_write = 1'b1; #1;
    total++;
    if (obsEnOut !== 2'b00) begin bad++; $display("[TB] FAIL obstacle_blocked got=%b exp=00", obsEnOut); end
    @(negedge clk); av_write = 1'b0; mErr = 1;
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_obs_err got=%h exp=%h", d, expStatus()); end
    busWrite(32'd1, 32'h8000_0000); mErr = 0;
    keep = mFonte[0];
    busWrite(32'd16, 32'(~keep)); mErr = 1;
    busRead(32'd16, d, lat);
    total++;
    if (d !== 32'(keep)) begin bad++; $display("[TB] FAIL fonte_locked got=%h exp=%h", d, keep); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_fonte_err got=%h exp=%h", d, expStatus()); end
    busWrite(32'd1, 32'h8000_0000); mErr = 0;
  endtask

  task automatic test_gma();
    logic [31:0] d; int lat, cyc; logic [AW-1:0] o1, o2;
    gmaData = {AW'($urandom_range(0, 255)), 8'h2A};
    busWrite(32'd0, 32'd0);
    busRead(32'(BGMA + 3), d, lat);
    total++;
    if (lat !== RDL + 1) begin bad++; $display("[TB] FAIL gma_latency got=%0d exp=%0d", lat, RDL + 1); end
    total++;
    if (d !== 32'h2A || gmaAddrOut !== 8'd3) begin bad++; $display("[TB] FAIL gma_read ch0 got=%h@%h exp=2a@03", d, gmaAddrOut); end
    busWrite(32'd0, 32'h100);
    o1 = AW'($urandom_range(0, 255));
    o2 = AW'($urandom_range(0, 255));
    @(negedge clk);
    av_addr = 32'(BGMA) + 32'(o1); av_read = 1'b1;
    @(negedge clk);
    av_addr = 32'(BGMA) + 32'(o2); #1;
    total++;
    if (av_wait !== 1'b1) begin bad++; $display("[TB] FAIL waitrequest_b2b got=%b exp=1", av_wait); end
    cyc = 0;
    while (av_wait && cyc < 20) begin @(negedge clk); #1; cyc++; end
    total++;
    if (cyc !== RDL) begin bad++; $display("[TB] FAIL waitrequest_len got=%0d exp=%0d", cyc, RDL); end
    total++;
    if (av_rvalid !== 1'b1 || av_rdata !== 32'(gmaData[AW +: AW])) begin
      bad++; $display("[TB] FAIL gma_first got=%b/%h exp=1/%h", av_rvalid, av_rdata, gmaData[AW +: AW]);
    end
    @(negedge clk); av_read = 1'b0;
    lat = 0;
    while (!av_rvalid && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (av_rvalid !== 1'b1 || av_rdata !== 32'(gmaData[AW +: AW]) || gmaAddrOut !== o2) begin
      bad++; $display("[TB] FAIL gma_second got=%b/%h@%h exp=1/%h@%h", av_rvalid, av_rdata, gmaAddrOut, gmaData[AW +: AW], o2);
    end
  endtask

  task automatic test_invalid_sel();
    logic [31:0] d; int lat;
    busWrite(32'd0, 32'h701); mErr = 1;
    total++;
    if (startOut !== 2'b00) begin bad++; $display("[TB] FAIL invalid_sel_start got=%b exp=00", startOut); end
    busRead(32'(BGMA + 5), d, lat);
    total++;
    if (d !== 32'd0 || lat < 1) begin bad++; $display("[TB] FAIL invalid_sel_gma got=%h lat=%0d exp=0", d, lat); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_invalid_sel got=%h exp=%h", d, expStatus()); end
    busWrite(32'd1, 32'h8000_0000); mErr = 0;
    busWrite(32'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; int lat, seen;
    applyStimulus(32'd0, 32'h003, 1'b1, 1'b1);
    mRun[0] = 0; mErr = 1;
    total++;
    if (abortOut !== 2'b01 || startOut !== 2'b00) begin
      bad++; $display("[TB] FAIL abort_wins got=%b/%b exp=01/00", abortOut, startOut);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (av_rvalid) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) begin bad++; $display("[TB] FAIL dropped_read got=%0d exp=0", seen); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_abort got=%h exp=%h", d, expStatus()); end
    busWrite(32'd1, 32'h8000_0000); mErr = 0;
    busWrite(32'd0, 32'h101); mRun[1] = 1;
    pronto[1] = 1'b1;
    @(negedge clk); @(negedge clk);
    pronto[1] = 1'b0; mRun[1] = 0; mDone[1] = 1;
    busWrite(32'd0, 32'h101); mErr = 1;
    total++;
    if (startOut !== 2'b00) begin bad++; $display("[TB] FAIL start_in_done got=%b exp=00", startOut); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_start_done got=%h exp=%h", d, expStatus()); end
    busWrite(32'd1, 32'h8002_0000); mErr = 0; mDone[1] = 0;
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_cleared got=%h exp=%h", d, expStatus()); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d; int lat, pulses;
    busWrite(32'd0, 32'h001);
    #1 rst_n = 1'b0; #1;
    modelReset();
    total++;
    if (startOut !== 2'b00 || fonteOut !== '0) begin
      bad++; $display("[TB] FAIL async_reset_outputs got=%b/%h exp=00/0", startOut, fonteOut);
    end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (startOut !== 2'b00 || abortOut !== 2'b00) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("[TB] FAIL pulses_after_reset got=%0d exp=0", pulses); end
    busRead(32'd1, d, lat);
    total++;
    if (d !== expStatus()) begin bad++; $display("[TB] FAIL status_after_reset got=%h exp=%h", d, expStatus()); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_registers();
    test_start_done();
    test_obstacle();
    test_gma();
    test_invalid_sel();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cae_mc.md
Name: cae_mc

Overview:
Multi-channel external access controller: the Avalon-MM slave bridge between a host CPU and NUM_CH path-search cores (each a top instance).
- Host writes source/destination per channel, writes the obstacle map into the selected channel, starts and aborts runs, polls or takes an interrupt on completion, and reads path results (GMA) back.
- Adds to the single-channel controller: per-channel run FSM, start/abort/W1C-done control, error flags, read pipeline with readdatavalid and waitrequest, and an interrupt.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH, grid node address width
AV_DATA_WIDTH, 32, Avalon data width (must be >= ADDR_WIDTH and >= 16+NUM_CH)
AV_ADDR_WIDTH, 32, Avalon word-address width
NUM_CH, 2, number of core channels (1..8)
RD_LATENCY, 1, core GMA read latency in cycles (0..4)
BASE_OBSTACULO, 1024, obstacle window base (window size 2^ADDR_WIDTH)
BASE_GMA, 4096, result window base (window size 2^ADDR_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
av_addr_in  in  AV_ADDR_WIDTH  word address
av_data_in  in  AV_DATA_WIDTH  write data
av_write_in  in  1  write strobe
av_read_in  in  1  read strobe
av_data_out  out  AV_DATA_WIDTH  read data
av_readdatavalid_out  out  1  read data valid
av_waitrequest_out  out  1  stall request
irq_out  out  1  level interrupt
core_addr_fonte_out  out  NUM_CH*ADDR_WIDTH  per-channel source
core_addr_destino_out  out  NUM_CH*ADDR_WIDTH  per-channel destination
core_start_out  out  NUM_CH  1-cycle start pulses
core_abort_out  out  NUM_CH  1-cycle abort pulses
core_pronto_in  in  NUM_CH  per-channel done level
obstaculos_wr_enable_out  out  NUM_CH  obstacle write enable
obstaculos_wr_addr_out  out  ADDR_WIDTH  obstacle node address
obstaculos_wr_data_out  out  1  obstacle bit
gma_read_addr_out  out  ADDR_WIDTH  result node address
gma_read_data_in  in  NUM_CH*ADDR_WIDTH  per-channel result data

Behaviour:
- Register map (word addresses):
  - 0 CTRL: W bit0 start, bit1 abort, bits[10:8] ch_sel; R returns ch_sel in [10:8].
  - 1 STATUS: R busy[NUM_CH-1:0], done[16+:NUM_CH], err bit31; W1C done bits and err.
  - 2 IRQ_EN: R/W, NUM_CH bits.
  - 16+2c FONTE[c], 17+2c DESTINO[c].
  - Obstacle window: write-only, routed to channel ch_sel.
  - GMA window: read-only, reads channel ch_sel.
  - Unmapped: reads return 0, writes ignored.
- Reset: all outputs 0; ch_sel, FONTE, DESTINO, IRQ_EN, err = 0; all channel FSMs IDLE.
- Channel FSM: IDLE, RUN, DONE.
  - IDLE + start -> RUN; core_start_out[c] pulses the next cycle.
  - RUN + core_pronto_in[c] high -> DONE.
  - DONE + W1C of done[c] -> IDLE.
  - Abort in any state -> IDLE; core_abort_out[c] pulses.
  - start in RUN or DONE: ignored, err set.
  - start and abort in the same write: abort wins.
- busy[c] = RUN; done[c] = DONE.
- Blocked writes:
  - FONTE/DESTINO write while channel RUN: ignored, err set.
  - Obstacle write while ch_sel RUN: ignored, err set.
  - ch_sel >= NUM_CH: start, abort, obstacle write and GMA read are no-ops that set err; GMA read returns 0.
- Obstacle write is combinational pass-through with the write strobe: enable[ch_sel] = 1, addr = av_addr - BASE_OBSTACULO, data = av_data_in[0].
- Register read: registered, readdatavalid exactly 1 cycle after the accepted read.
- GMA read:
  - gma_read_addr_out registered at accept.
  - Data captured RD_LATENCY cycles later, zero-extended.
  - readdatavalid RD_LATENCY+1 cycles after accept.
- At most one read outstanding. waitrequest is combinational: high when av_read_in is asserted while a read is in flight. Writes are never stalled.
- av_read_in and av_write_in together: write performed, read dropped (no readdatavalid), err set.
- irq_out registered: |(done & IRQ_EN), one cycle after the state change.
- Async reset mid-run: all pulses and readdatavalid drop immediately; no further pulses follow.

Decomposition:
- Shared package/defines (cae_defs.vh): register offsets, CTRL bit positions, STATUS field offsets, FSM state encodings.
- One sub-module, cae_canal_fsm: the per-channel FSM, instantiated NUM_CH times via generate.
- Read pipeline and decoding stay in cae_mc.

Test Plan:
- Reset, then read STATUS -> readdatavalid 1 cycle later; data 0; irq_out 0.
- Write FONTE[1]=5, DESTINO[1]=9, CTRL=0x101 -> core_start_out=2'b10 for one cycle; core_addr_fonte_out[1]=5; STATUS reads 0x00000002.
- Hold core_pronto_in[1] high with IRQ_EN=2 -> STATUS 0x00020000; irq_out 1 one cycle after DONE. W1C 0x00020000 -> channel 1 IDLE, irq_out 0.
- ch_sel=0, write obstacle addr BASE_OBSTACULO+7 data 1 -> obstaculos_wr_enable_out=01, addr 7, data 1. Repeat while channel 0 RUN -> no enable; STATUS bit31 set.
- RD_LATENCY=2: read BASE_GMA+3 with gma_read_data_in[ch0]=0x2A -> gma_read_addr_out=3; readdatavalid at +3 with data 0x2A. A back-to-back read sees waitrequest high until then.
- Abort during RUN plus a simultaneous read/write -> core_abort pulse, channel IDLE; read dropped, err set; CTRL start in DONE also sets err and gives no pulse.
